// File: rtl/mem_wb_pipe_unit.sv
// MEM->WB pipeline register with a two-entry skid buffer, writeback data select
// and a saturating back-pressure counter.
module mem_wb_pipe_unit #(
   parameter int          CORE       = 0,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_BITS   = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic                  mem_regWrite,
   input  logic                  mem_memRead,
   input  logic [REG_BITS-1:0]   mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_memory_data,
   input  logic [DATA_WIDTH-1:0] mem_ALU_result,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_regWrite,
   output logic                  wb_memRead,
   output logic [REG_BITS-1:0]   wb_rd,
   output logic [DATA_WIDTH-1:0] wb_write_data,
   output logic [CNT_WIDTH-1:0]  stall_count
);

   localparam logic [CNT_WIDTH-1:0] STALL_MAX = '1;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_BITS-1:0]   rd;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   // The core index is a pure tag; only reject nonsensical values.
   if (CORE < 0) begin : g_core_check
      $error("mem_wb_pipe_unit: CORE must be non-negative");
   end

   state_t                 state, state_nxt;
   entry_t                 main_q, main_nxt;
   entry_t                 skid_q, skid_nxt;
   entry_t                 in_entry;
   logic                   ready_q, ready_nxt;
   logic                   valid_q, valid_nxt;
   logic [CNT_WIDTH-1:0]   stall_q, stall_nxt;
   logic                   accept;
   logic                   consume;

   // State and datapath registers; reset clears held entries immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         stall_q <= '0;
      end else begin
         state   <= state_nxt;
         main_q  <= main_nxt;
         skid_q  <= skid_nxt;
         ready_q <= ready_nxt;
         valid_q <= valid_nxt;
         stall_q <= stall_nxt;
      end
   end

   // Next-state, entry movement and counter update.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      stall_nxt = stall_q;

      accept  = mem_valid & ready_q;
      consume = valid_q & wb_ready;

      in_entry.reg_write = mem_regWrite & (mem_rd != '0);
      in_entry.mem_read  = mem_memRead;
      in_entry.rd        = mem_rd;
      in_entry.data      = mem_memRead ? mem_memory_data : mem_ALU_result;

      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (accept) begin
                  main_nxt  = in_entry;
                  state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (accept && consume) begin
                  main_nxt = in_entry;
               end else if (accept) begin
                  skid_nxt  = in_entry;
                  state_nxt = S_FULL;
               end else if (consume) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (consume) begin
                  main_nxt  = skid_q;
                  state_nxt = S_ONE;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end

      ready_nxt = (state_nxt != S_FULL);
      valid_nxt = (state_nxt != S_EMPTY);

      // Back-pressure counting ignores flush on purpose.
      if (mem_valid && !ready_q && (stall_q != STALL_MAX)) begin
         stall_nxt = stall_q + CNT_WIDTH'(1);
      end
   end

   assign mem_ready     = ready_q;
   assign wb_valid      = valid_q;
   assign wb_regWrite   = main_q.reg_write;
   assign wb_memRead    = main_q.mem_read;
   assign wb_rd         = main_q.rd;
   assign wb_write_data = main_q.data;
   assign stall_count   = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe_unit.sv
// Directed bench for mem_wb_pipe_unit: scoreboard of expected writebacks plus
// point checks on handshake, flush, counter saturation and async reset.
module tb_mem_wb_pipe_unit;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        mem_valid;
   logic        mem_regWrite;
   logic        mem_memRead;
   logic [4:0]  mem_rd;
   logic [31:0] mem_memory_data;
   logic [31:0] mem_ALU_result;
   logic        wb_ready;

   logic        mem_ready, wb_valid, wb_regWrite, wb_memRead;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
   logic [15:0] stall_count;

   logic        mem_ready4, wb_valid4, wb_regWrite4, wb_memRead4;
   logic [4:0]  wb_rd4;
   logic [31:0] wb_write_data4;
   logic [3:0]  stall_count4;

   typedef struct packed {
      logic        rw;
      logic        mr;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   mem_wb_pipe_unit dut (
      .clock(clk), .reset(rst_n), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .mem_memory_data(mem_memory_data), .mem_ALU_result(mem_ALU_result),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_regWrite(wb_regWrite),
      .wb_memRead(wb_memRead), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
      .stall_count(stall_count)
   );

   mem_wb_pipe_unit #(.CNT_WIDTH(4)) dut4 (
      .clock(clk), .reset(rst_n), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready4),
      .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .mem_memory_data(mem_memory_data), .mem_ALU_result(mem_ALU_result),
      .wb_valid(wb_valid4), .wb_ready(wb_ready), .wb_regWrite(wb_regWrite4),
      .wb_memRead(wb_memRead4), .wb_rd(wb_rd4), .wb_write_data(wb_write_data4),
      .stall_count(stall_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                        input logic [31:0] md, input logic [31:0] alu);
      mem_valid       = v;
      mem_regWrite    = rw;
      mem_memRead     = mr;
      mem_rd          = rd;
      mem_memory_data = md;
      mem_ALU_result  = alu;
   endtask

   function automatic exp_t mk(input logic rw, input logic mr, input logic [4:0] rd,
                               input logic [31:0] md, input logic [31:0] alu);
      exp_t e;
      e.rw   = rw & (rd != 5'd0);
      e.mr   = mr;
      e.rd   = rd;
      e.data = mr ? md : alu;
      return e;
   endfunction

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         step();
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // Scoreboard: every consume pops the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && !flush && wb_valid && wb_ready) begin
         total++;
         assert (q.size() != 0) else begin
            bad++;
            $error("FAIL wb_spurious observed rd=%0d expected no entry", wb_rd);
         end
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_rd", 64'(wb_rd), 64'(e.rd));
            chk("sb_data", 64'(wb_write_data), 64'(e.data));
            chk("sb_regwrite", 64'(wb_regWrite), 64'(e.rw));
            chk("sb_memread", 64'(wb_memRead), 64'(e.mr));
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

      // Reset state
      #12;
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_regwrite", 64'(wb_regWrite), 64'd0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_wb_data", 64'(wb_write_data), 64'd0);
      chk("rst_stall", 64'(stall_count), 64'd0);
      rst_n = 1'b1;
      step();
      chk("ready_after_rst", 64'(mem_ready), 64'd1);

      // Stream: one entry per cycle, one-cycle latency
      wb_ready = 1'b1;
      for (int r = 1; r <= 8; r++) begin
         drive(1'b1, 1'b1, 1'b0, 5'(r), 32'hFFFF_0000 | 32'(r), 32'(r * 16));
         q.push_back(mk(1'b1, 1'b0, 5'(r), 32'hFFFF_0000 | 32'(r), 32'(r * 16)));
         step();
         if (r == 1) begin
            chk("lat_wb_valid", 64'(wb_valid), 64'd1);
            chk("lat_wb_rd", 64'(wb_rd), 64'd1);
            chk("lat_wb_data", 64'(wb_write_data), 64'h10);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      drain();
      chk("stream_stall", 64'(stall_count), 64'd0);

      // Back-pressure: 3 offered while stalled, 2 held
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'h900);
      q.push_back(mk(1'b1, 1'b0, 5'd9, 32'd0, 32'h900));
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd10, 32'd0, 32'hA00);
      q.push_back(mk(1'b1, 1'b0, 5'd10, 32'd0, 32'hA00));
      step();
      drive(1'b1, 1'b1, 1'b1, 5'd11, 32'hB0B0, 32'hB00);
      q.push_back(mk(1'b1, 1'b1, 5'd11, 32'hB0B0, 32'hB00));
      step();
      step();
      chk("bp_mem_ready", 64'(mem_ready), 64'd0);
      chk("bp_wb_valid", 64'(wb_valid), 64'd1);
      chk("bp_hold_rd", 64'(wb_rd), 64'd9);
      chk("bp_hold_data", 64'(wb_write_data), 64'h900);
      chk("bp_stall", 64'(stall_count), 64'd2);
      wb_ready = 1'b1;
      step();
      chk("bp_ready_back", 64'(mem_ready), 64'd1);
      step();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      drain();
      chk("bp_stall_final", 64'(stall_count), 64'd3);

      // Writeback mux and rd=0 suppression
      drive(1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1234);
      q.push_back(mk(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h1234));
      step();
      chk("mux_load_data", 64'(wb_write_data), 64'hDEAD_BEEF);
      drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h55);
      q.push_back(mk(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h55));
      step();
      chk("rd0_regwrite", 64'(wb_regWrite), 64'd0);
      drive(1'b1, 1'b0, 1'b0, 5'd7, 32'd0, 32'h77);
      q.push_back(mk(1'b0, 1'b0, 5'd7, 32'd0, 32'h77));
      step();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      drain();

      // Flush while FULL with an entry offered
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 5'd12, 32'd0, 32'hC00);
      step();
      drive(1'b1, 1'b1, 1'b0, 5'd13, 32'd0, 32'hD00);
      step();
      chk("fl_full", 64'(mem_ready), 64'd0);
      drive(1'b1, 1'b1, 1'b0, 5'd14, 32'd0, 32'hE00);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_wb_valid", 64'(wb_valid), 64'd0);
      chk("fl_mem_ready", 64'(mem_ready), 64'd1);
      chk("fl_stall", 64'(stall_count), 64'd4);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      wb_ready = 1'b1;
      step();
      step();
      chk("fl_no_ghost", 64'(wb_valid), 64'd0);

      // Counter saturation on the narrow instance
      wb_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 5'd15, 32'd0, 32'hF00);
      for (int i = 0; i < 22; i++) step();
      chk("cnt16_stall", 64'(stall_count), 64'd24);
      chk("cnt4_sat", 64'(stall_count4), 64'd15);
      step();
      step();
      chk("cnt4_hold", 64'(stall_count4), 64'd15);
      chk("cnt16_more", 64'(stall_count), 64'd26);

      // Asynchronous reset between edges while FULL
      chk("ar_pre_regwrite", 64'(wb_regWrite), 64'd1);
      chk("ar_pre_valid", 64'(wb_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_wb_valid", 64'(wb_valid), 64'd0);
      chk("ar_wb_regwrite", 64'(wb_regWrite), 64'd0);
      chk("ar_stall", 64'(stall_count), 64'd0);
      chk("ar_stall4", 64'(stall_count4), 64'd0);
      chk("ar_mem_ready", 64'(mem_ready), 64'd0);
      q.delete();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("ar_ready_after", 64'(mem_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_pipe_unit.md
MEM_WB_PIPE_UNIT -- requirements
Module: mem_wb_pipe_unit

Interface
REQ-001 Parameter CORE, default 0, core index tag; no functional effect.
REQ-002 Parameter DATA_WIDTH, default 32, width of memory data, ALU result and writeback data.
REQ-003 Parameter REG_BITS, default 5, width of the destination register index.
REQ-004 Parameter CNT_WIDTH, default 16, width of the stall counter.
REQ-005 clock  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-007 flush  input  1  synchronous pipeline flush.
REQ-008 mem_valid  input  1  MEM-stage entry valid.
REQ-009 mem_ready  output  1  block can accept an entry this cycle.
REQ-010 mem_regWrite  input  1  entry writes the register file.
REQ-011 mem_memRead  input  1  entry is a load.
REQ-012 mem_rd  input  REG_BITS  destination register.
REQ-013 mem_memory_data  input  DATA_WIDTH  load data.
REQ-014 mem_ALU_result  input  DATA_WIDTH  ALU result.
REQ-015 wb_valid  output  1  WB-stage entry valid.
REQ-016 wb_ready  input  1  WB stage consumes the entry this cycle.
REQ-017 wb_regWrite  output  1  qualified register write enable.
REQ-018 wb_memRead  output  1  entry was a load.
REQ-019 wb_rd  output  REG_BITS  destination register.
REQ-020 wb_write_data  output  DATA_WIDTH  selected writeback data.
REQ-021 stall_count  output  CNT_WIDTH  saturating count of back-pressure cycles.

Function
REQ-022 Storage: two entries, main (drives wb_* outputs) and skid; state EMPTY (0 entries), ONE (main only) or FULL (main and skid).
REQ-023 Accept = mem_valid & mem_ready; consume = wb_valid & wb_ready.
REQ-024 mem_ready is registered: 1 in EMPTY and ONE, 0 in FULL.
REQ-025 wb_valid is 1 in ONE and FULL, 0 in EMPTY.
REQ-026 Transitions: EMPTY+accept -> ONE; ONE+accept & !consume -> FULL (entry to skid); ONE+accept & consume -> ONE (new entry to main); ONE+consume & !accept -> EMPTY; FULL+consume -> ONE (skid moves to main); all other cases hold.
REQ-027 Latency: an entry accepted at edge N is visible on wb_* after edge N when the block is EMPTY or when ONE with simultaneous consume.
REQ-028 Order is preserved; no entry is dropped or duplicated except by flush or reset.
REQ-029 wb_write_data is captured at accept as mem_memRead ? mem_memory_data : mem_ALU_result.
REQ-030 wb_regWrite is captured as mem_regWrite & (mem_rd != 0); writes to register 0 are suppressed.
REQ-031 wb_* data outputs hold their value while wb_valid=1 & wb_ready=0.
REQ-032 Flush has priority over accept and consume: the next state is EMPTY, the input that cycle is discarded, and mem_ready becomes 1.
REQ-033 stall_count increments by 1 each cycle with mem_valid=1 & mem_ready=0, saturates at 2^CNT_WIDTH-1, and is unaffected by flush.

Reset
REQ-034 While reset=0: state EMPTY, mem_ready=0, wb_valid=0, wb_regWrite=0, wb_memRead=0, wb_rd=0, wb_write_data=0, stall_count=0.
REQ-035 The first posedge after reset deasserts sets mem_ready=1.
REQ-036 Reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.

Verification
REQ-037 Stream test: wb_ready=1, mem_valid=1, rd=1..8, ALU=rd*16, memRead=0 -> wb_valid and wb_rd=1..8 in order, one cycle later, wb_write_data=0x10..0x80, stall_count=0.
REQ-038 Back-pressure test: wb_ready=0 for 4 cycles while 3 entries are offered -> 2 entries held, mem_ready=0, stall_count=2 after 4 cycles; with wb_ready=1, entries drain in order with no loss.
REQ-039 Mux and rd=0 test: memRead=1, memory_data=0xDEADBEEF, ALU=0x1234 -> wb_write_data=0xDEADBEEF; rd=0 with regWrite=1 -> wb_regWrite=0.
REQ-040 Flush test: FULL state, flush=1 with mem_valid=1 -> next cycle wb_valid=0, mem_ready=1; the offered entry never appears on wb_*.
REQ-041 Counter test: CNT_WIDTH=4, stalled for 20 cycles -> stall_count=15, held at 15.
REQ-042 Async reset test: reset=0 applied between edges while FULL -> wb_valid=0, wb_regWrite=0 and stall_count=0 immediately, before the next edge.
